// File: rtl/mips_pkg.sv
// Shared helpers for the MIPS register file: byte-lane merge used by write and bypass paths.
// Latency: purely combinational helpers.
// Backpressure: none.
package mips_pkg;

    localparam int MAXW = 128;
    localparam int MAXL = MAXW / 8;

    typedef logic [7:0] lane_t;

    // Lanes with mask=1 take new_dat, others keep old_dat; callers size-cast to/from MAXW.
    function automatic logic [MAXW-1:0] lane_merge(input logic [MAXW-1:0] old_dat,
                                                   input logic [MAXW-1:0] new_dat,
                                                   input logic [MAXL-1:0] mask);
        logic [MAXW-1:0] res;
        for (int i = 0; i < MAXL; i++)
            res[8*i +: 8] = mask[i] ? new_dat[8*i +: 8] : old_dat[8*i +: 8];
        return res;
    endfunction

endpackage

// File: rtl/mips_rfile_if.sv
// Register-file bus: writeback write port, decode read addresses, read data and busy.
// Latency: wires only.
// Backpressure: busy tells the pipeline the file is still clearing.
interface mips_rfile_if #(
    parameter int W     = 32,
    parameter int AW    = 5,
    parameter int READS = 2
);
    logic                 busy;
    logic [AW-1:0]        rd;
    logic [W/8-1:0]       we;
    logic [W-1:0]         D;
    logic [READS*AW-1:0]  ra;
    logic [READS*W-1:0]   Q;

    modport master (input busy, Q, output rd, we, D, ra);
    modport slave  (output busy, Q, input rd, we, D, ra);
endinterface

// File: rtl/mips_rfile_port.sv
// One read port: same-cycle write bypass plus zero-register and busy overrides.
// Latency: combinational from ra/rd/we/D/stored.
// Backpressure: forces zero while busy.
module mips_rfile_port
    import mips_pkg::*;
#(
    parameter int W      = 32,
    parameter int AW     = 5,
    parameter int ZERO   = 1,
    parameter int BYPASS = 1
) (
    input  logic           busy,
    input  logic [AW-1:0]  ra,
    input  logic [AW-1:0]  rd,
    input  logic [W/8-1:0] we,
    input  logic [W-1:0]   D,
    input  logic [W-1:0]   stored,
    output logic [W-1:0]   q
);

    always_comb begin
        q = stored;
        if (BYPASS != 0 && ra == rd)
            q = W'(lane_merge(MAXW'(stored), MAXW'(D), MAXL'(we)));
        // Zero rule wins over bypass, and nothing valid is stored until the sweep ends.
        if (busy || (ZERO != 0 && ra == '0))
            q = '0;
    end

endmodule

// File: rtl/mips_rfile.sv
// Parametrised register file with byte-lane writes, bypass and post-reset clear sweep.
// Latency: reads combinational; writes visible from storage after the edge.
// Backpressure: busy high for 2**AW edges after reset; writes ignored meanwhile.
module mips_rfile
    import mips_pkg::*;
#(
    parameter int W      = 32,
    parameter int AW     = 5,
    parameter int READS  = 2,
    parameter int ZERO   = 1,
    parameter int BYPASS = 1
) (
    input  logic        clock,
    input  logic        reset,
    mips_rfile_if.slave bus
);

    localparam int LANES = W / 8;
    localparam int DEPTH = 2 ** AW;

    logic [AW:0]      cnt;
    logic             busy;
    logic [AW-1:0]    wr_addr;
    logic [LANES-1:0] wr_mask;
    logic [W-1:0]     wr_dat;

    // The counter stops at DEPTH; its top bit doubles as the end-of-sweep flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (busy)
            cnt <= cnt + 1'b1;
    end

    assign busy     = ~cnt[AW];
    assign bus.busy = busy;

    always_comb begin
        wr_addr = busy ? cnt[AW-1:0] : bus.rd;
        wr_mask = busy ? '1 : bus.we;
        if (!busy && ZERO != 0 && bus.rd == '0)
            wr_mask = '0;
        wr_dat  = W'(lane_merge(MAXW'(bus.D), '0, MAXL'({LANES{busy}})));
    end

    for (genvar p = 0; p < READS; p++) begin : g_port
        // One bank per read port so each lane maps to a 1W/1R RAM with no reset.
        lane_t         lane_mem [LANES][DEPTH];
        logic [AW-1:0] ra_p;
        logic [W-1:0]  stored;
        logic [W-1:0]  q_p;

        always_ff @(posedge clock) begin
            for (int l = 0; l < LANES; l++)
                if (wr_mask[l])
                    lane_mem[l][wr_addr] <= wr_dat[8*l +: 8];
        end

        assign ra_p = bus.ra[p*AW +: AW];

        always_comb begin
            stored = '0;
            for (int l = 0; l < LANES; l++)
                stored[8*l +: 8] = lane_mem[l][ra_p];
        end

        mips_rfile_port #(
            .W      (W),
            .AW     (AW),
            .ZERO   (ZERO),
            .BYPASS (BYPASS)
        ) u_port (
            .busy   (busy),
            .ra     (ra_p),
            .rd     (bus.rd),
            .we     (bus.we),
            .D      (bus.D),
            .stored (stored),
            .q      (q_p)
        );

        assign bus.Q[p*W +: W] = q_p;
    end

endmodule
